// File: rtl/bip_pkg.sv
// Shared constants for the BIP sequencer: opcodes, accumulator/ALU source
// encodings and the control FSM state type.
package bip_pkg;

   // Instruction set; any opcode above OP_BR is undefined and runs as a NOP
   localparam int unsigned OP_HLT  = 0;
   localparam int unsigned OP_STO  = 1;
   localparam int unsigned OP_LD   = 2;
   localparam int unsigned OP_LDI  = 3;
   localparam int unsigned OP_ADD  = 4;
   localparam int unsigned OP_ADDI = 5;
   localparam int unsigned OP_SUB  = 6;
   localparam int unsigned OP_SUBI = 7;
   localparam int unsigned OP_BEQ  = 8;
   localparam int unsigned OP_BNE  = 9;
   localparam int unsigned OP_BR   = 10;

   // Accumulator source select
   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_ALU = 2'b10;

   // ALU B operand source select
   localparam logic SEL_B_MEM = 1'b0;
   localparam logic SEL_B_IMM = 1'b1;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/bip_branch_pc.sv
// Program counter with its increment / relative-branch adder. The offset is
// sign-extended and all arithmetic wraps at the PC width.
module bip_branch_pc #(
   parameter int PC_CANT_BITS = 11,
   parameter int OFFSET_BITS  = 11
) (
   input  logic                    i_clock,
   input  logic                    i_soft_reset,
   input  logic                    wrPC,
   input  logic                    branch,
   input  logic [OFFSET_BITS-1:0]  offset,
   output logic [PC_CANT_BITS-1:0] pc
);

   // Wide enough to hold both the PC and the offset so sign extension is exact
   localparam int EXT_BITS = (OFFSET_BITS > PC_CANT_BITS) ? OFFSET_BITS : PC_CANT_BITS;

   logic [EXT_BITS-1:0]     offset_ext;
   logic [PC_CANT_BITS-1:0] pc_inc;
   logic [PC_CANT_BITS-1:0] pc_target;

   assign offset_ext = EXT_BITS'($signed(offset));
   assign pc_inc     = pc + PC_CANT_BITS'(1);
   assign pc_target  = pc_inc + offset_ext[PC_CANT_BITS-1:0];

   // PC advances only when the sequencer retires an instruction
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         pc <= '0;
      end else if (wrPC) begin
         pc <= branch ? pc_target : pc_inc;
      end
   end

endmodule

// File: rtl/bip_seq_control.sv
// BIP control unit: fetches one instruction word per handshake, decodes it
// for a single EXEC cycle and steers the PC, then refetches or halts.
module bip_seq_control #(
   parameter int PC_CANT_BITS   = 11,
   parameter int OPCODE_LENGTH  = 5,
   parameter int OPERAND_LENGTH = 11
) (
   input  logic                                  i_clock,
   input  logic                                  i_soft_reset,
   input  logic                                  i_start,
   input  logic [OPCODE_LENGTH+OPERAND_LENGTH-1:0] i_instr,
   input  logic                                  i_imem_ack,
   input  logic                                  i_acc_zero,
   output logic [PC_CANT_BITS-1:0]               o_addr_mem,
   output logic                                  o_imem_req,
   output logic [OPERAND_LENGTH-1:0]             o_operand,
   output logic [1:0]                            o_selA,
   output logic                                  o_selB,
   output logic                                  o_wrAcc,
   output logic                                  o_wr_rd_mem,
   output logic [OPCODE_LENGTH-1:0]              o_opCode,
   output logic                                  o_busy,
   output logic                                  o_halted,
   output logic                                  o_illegal
);

   import bip_pkg::*;

   localparam int INSTR_W = OPCODE_LENGTH + OPERAND_LENGTH;

   state_t                    state;
   state_t                    state_next;
   logic [INSTR_W-1:0]        instr_q;
   logic [OPCODE_LENGTH-1:0]  opcode;
   logic [OPERAND_LENGTH-1:0] operand;
   logic                      in_exec;
   logic                      is_halt;
   logic                      branch_taken;
   logic                      wr_pc;

   assign opcode    = instr_q[INSTR_W-1 -: OPCODE_LENGTH];
   assign operand   = instr_q[OPERAND_LENGTH-1:0];
   assign in_exec   = (state == ST_EXEC);
   assign is_halt   = (opcode == OPCODE_LENGTH'(OP_HLT));
   assign wr_pc     = in_exec && !is_halt;
   assign o_operand = operand;

   // HLT leaves the PC pointing at itself, everything else retires the PC
   bip_branch_pc #(
      .PC_CANT_BITS (PC_CANT_BITS),
      .OFFSET_BITS  (OPERAND_LENGTH)
   ) u_pc (
      .i_clock      (i_clock),
      .i_soft_reset (i_soft_reset),
      .wrPC         (wr_pc),
      .branch       (branch_taken),
      .offset       (operand),
      .pc           (o_addr_mem)
   );

   // State register
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the instruction word only on an acknowledged fetch
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         instr_q <= '0;
      end else if (state == ST_FETCH && i_imem_ack) begin
         instr_q <= i_instr;
      end
   end

   // Next-state logic; HALT is only left through reset
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (i_start) state_next = ST_FETCH;
         ST_FETCH: if (i_imem_ack) state_next = ST_EXEC;
         ST_EXEC:  state_next = is_halt ? ST_HALT : ST_FETCH;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Branch decision, using the zero flag as seen during EXEC
   always_comb begin
      branch_taken = 1'b0;
      case (opcode)
         OPCODE_LENGTH'(OP_BR):  branch_taken = 1'b1;
         OPCODE_LENGTH'(OP_BEQ): branch_taken = i_acc_zero;
         OPCODE_LENGTH'(OP_BNE): branch_taken = !i_acc_zero;
         default:                branch_taken = 1'b0;
      endcase
   end

   // Output decode: status flags per state, datapath controls only in EXEC
   always_comb begin
      o_imem_req  = (state == ST_FETCH);
      o_busy      = (state == ST_FETCH) || in_exec;
      o_halted    = (state == ST_HALT);
      o_selA      = SEL_A_MEM;
      o_selB      = SEL_B_MEM;
      o_wrAcc     = 1'b0;
      o_wr_rd_mem = 1'b0;
      o_illegal   = 1'b0;
      o_opCode    = '0;
      if (in_exec) begin
         o_opCode = opcode;
         case (opcode)
            OPCODE_LENGTH'(OP_HLT): ;
            OPCODE_LENGTH'(OP_STO): o_wr_rd_mem = 1'b1;
            OPCODE_LENGTH'(OP_LD): begin
               o_selA  = SEL_A_MEM;
               o_wrAcc = 1'b1;
            end
            OPCODE_LENGTH'(OP_LDI): begin
               o_selA  = SEL_A_IMM;
               o_wrAcc = 1'b1;
            end
            OPCODE_LENGTH'(OP_ADD), OPCODE_LENGTH'(OP_SUB): begin
               o_selA  = SEL_A_ALU;
               o_selB  = SEL_B_MEM;
               o_wrAcc = 1'b1;
            end
            OPCODE_LENGTH'(OP_ADDI), OPCODE_LENGTH'(OP_SUBI): begin
               o_selA  = SEL_A_ALU;
               o_selB  = SEL_B_IMM;
               o_wrAcc = 1'b1;
            end
            OPCODE_LENGTH'(OP_BEQ), OPCODE_LENGTH'(OP_BNE), OPCODE_LENGTH'(OP_BR): ;
            default: o_illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_bip_seq_control.sv
// Self-checking bench for bip_seq_control: a default-width instance and a
// 4-bit-PC instance share the memory-side stimulus; a mux selects which one
// is observed.
module tb_bip_seq_control;

   typedef struct packed {
      logic [15:0] instr;
      logic        zero;
      int          delay;
      logic [10:0] expPc;
   } vec_t;

   typedef struct packed {
      logic [1:0]  selA;
      logic        selB;
      logic        wrAcc;
      logic        wrMem;
      logic        illegal;
      logic        halt;
      logic [4:0]  opCode;
      logic [10:0] operand;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetA, resetB, startA, startB;
   logic [15:0] instr;
   logic        ack, accZero;
   logic        useB;

   logic [10:0] aAddr;   logic [3:0] bAddr;
   logic        aReq, bReq;
   logic [10:0] aOperand, bOperand;
   logic [1:0]  aSelA, bSelA;
   logic        aSelB, bSelB, aWrAcc, bWrAcc, aWrMem, bWrMem;
   logic [4:0]  aOp, bOp;
   logic        aBusy, bBusy, aHalted, bHalted, aIllegal, bIllegal;

   logic [10:0] obsAddr, obsOperand;
   logic        obsReq, obsSelB, obsWrAcc, obsWrMem, obsBusy, obsHalted, obsIllegal;
   logic [1:0]  obsSelA;
   logic [4:0]  obsOp;

   int   checks = 0;
   int   errors = 0;
   logic [10:0] modelPc;
   exp_t sb[$];

   vec_t tableA[15];
   vec_t tableB1[4];
   vec_t tableB2[5];

   always #5 clock = ~clock;

   bip_seq_control dutA (
      .i_clock(clock), .i_soft_reset(resetA), .i_start(startA), .i_instr(instr),
      .i_imem_ack(ack), .i_acc_zero(accZero), .o_addr_mem(aAddr), .o_imem_req(aReq),
      .o_operand(aOperand), .o_selA(aSelA), .o_selB(aSelB), .o_wrAcc(aWrAcc),
      .o_wr_rd_mem(aWrMem), .o_opCode(aOp), .o_busy(aBusy), .o_halted(aHalted),
      .o_illegal(aIllegal)
   );

   bip_seq_control #(.PC_CANT_BITS(4)) dutB (
      .i_clock(clock), .i_soft_reset(resetB), .i_start(startB), .i_instr(instr),
      .i_imem_ack(ack), .i_acc_zero(accZero), .o_addr_mem(bAddr), .o_imem_req(bReq),
      .o_operand(bOperand), .o_selA(bSelA), .o_selB(bSelB), .o_wrAcc(bWrAcc),
      .o_wr_rd_mem(bWrMem), .o_opCode(bOp), .o_busy(bBusy), .o_halted(bHalted),
      .o_illegal(bIllegal)
   );

   // Route the currently observed instance to a common set of signals
   always_comb begin
      obsAddr    = useB ? {7'd0, bAddr} : aAddr;
      obsReq     = useB ? bReq     : aReq;
      obsOperand = useB ? bOperand : aOperand;
      obsSelA    = useB ? bSelA    : aSelA;
      obsSelB    = useB ? bSelB    : aSelB;
      obsWrAcc   = useB ? bWrAcc   : aWrAcc;
      obsWrMem   = useB ? bWrMem   : aWrMem;
      obsOp      = useB ? bOp      : aOp;
      obsBusy    = useB ? bBusy    : aBusy;
      obsHalted  = useB ? bHalted  : aHalted;
      obsIllegal = useB ? bIllegal : aIllegal;
   end

   function automatic logic [15:0] mk(input int op, input int opnd);
      return {op[4:0], opnd[10:0]};
   endfunction

   // Reference decode of the instruction set
   function automatic exp_t model(input logic [15:0] w);
      exp_t e;
      e = '0;
      e.opCode  = w[15:11];
      e.operand = w[10:0];
      case (w[15:11])
         5'd0:       e.halt = 1'b1;
         5'd1:       e.wrMem = 1'b1;
         5'd2:       begin e.selA = 2'b00; e.wrAcc = 1'b1; end
         5'd3:       begin e.selA = 2'b01; e.wrAcc = 1'b1; end
         5'd4, 5'd6: begin e.selA = 2'b10; e.selB = 1'b0; e.wrAcc = 1'b1; end
         5'd5, 5'd7: begin e.selA = 2'b10; e.selB = 1'b1; e.wrAcc = 1'b1; end
         5'd8, 5'd9, 5'd10: ;
         default:    e.illegal = 1'b1;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_ctrl"}, {obsSelA, obsSelB, obsWrAcc, obsWrMem, obsIllegal, obsOp}, 0);
      checkOutput({name, "_status"}, {obsReq, obsBusy, obsHalted}, 0);
      checkOutput({name, "_pc"}, obsAddr, 0);
      checkOutput({name, "_operand"}, obsOperand, 0);
   endtask

   // Serve one fetch after 'delay' idle request cycles, then check its EXEC
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int   n;
      for (int d = 0; d < v.delay; d++) begin
         checkOutput("fetch_req_held", obsReq, 1);
         checkOutput("fetch_pc_stable", obsAddr, modelPc);
         checkOutput("fetch_no_ctrl", {obsSelA, obsSelB, obsWrAcc, obsWrMem, obsIllegal, obsOp}, 0);
         tick();
      end
      instr = v.instr;
      ack   = 1'b1;
      sb.push_back(model(v.instr));
      tick();
      ack     = 1'b0;
      accZero = v.zero;
      #1;
      n = 0;
      while (!(obsBusy && !obsReq) && n < 4) begin
         tick();
         n++;
      end
      checkOutput("exec_seen", obsBusy && !obsReq, 1);
      e = sb.pop_front();
      checkOutput("exec_selA", obsSelA, e.selA);
      checkOutput("exec_selB", obsSelB, e.selB);
      checkOutput("exec_wrAcc", obsWrAcc, e.wrAcc);
      checkOutput("exec_wrMem", obsWrMem, e.wrMem);
      checkOutput("exec_illegal", obsIllegal, e.illegal);
      checkOutput("exec_opCode", obsOp, e.opCode);
      checkOutput("exec_operand", obsOperand, e.operand);
      checkOutput("exec_pc", obsAddr, modelPc);
      tick();
      checkOutput("next_pc", obsAddr, v.expPc);
      checkOutput("after_illegal_clear", obsIllegal, 0);
      if (e.halt) checkOutput("halted", {obsHalted, obsBusy}, 2'b10);
      else        checkOutput("refetch", {obsReq, obsHalted}, 2'b10);
      modelPc = v.expPc;
   endtask

   initial begin
      tableA[0]  = '{mk(3, 5),   1'b0, 1, 11'd1};
      tableA[1]  = '{mk(5, 3),   1'b0, 4, 11'd2};
      tableA[2]  = '{mk(1, 7),   1'b0, 1, 11'd3};
      tableA[3]  = '{mk(31, 0),  1'b0, 0, 11'd4};
      tableA[4]  = '{mk(2, 9),   1'b0, 1, 11'd5};
      tableA[5]  = '{mk(8, -2),  1'b1, 1, 11'd4};
      tableA[6]  = '{mk(4, 1),   1'b0, 0, 11'd5};
      tableA[7]  = '{mk(8, -2),  1'b0, 1, 11'd6};
      tableA[8]  = '{mk(9, -2),  1'b0, 1, 11'd5};
      tableA[9]  = '{mk(6, 2),   1'b0, 2, 11'd6};
      tableA[10] = '{mk(9, -2),  1'b1, 1, 11'd7};
      tableA[11] = '{mk(7, 1),   1'b0, 0, 11'd8};
      tableA[12] = '{mk(10, 2),  1'b0, 1, 11'd11};
      tableA[13] = '{mk(12, 0),  1'b0, 1, 11'd12};
      tableA[14] = '{mk(0, 0),   1'b0, 1, 11'd12};

      tableB1[0] = '{mk(3, 5),   1'b0, 1, 11'd1};
      tableB1[1] = '{mk(5, 3),   1'b0, 1, 11'd2};
      tableB1[2] = '{mk(1, 7),   1'b0, 1, 11'd3};
      tableB1[3] = '{mk(0, 0),   1'b0, 1, 11'd3};

      tableB2[0] = '{mk(10, 13), 1'b0, 1, 11'd14};
      tableB2[1] = '{mk(10, 3),  1'b0, 1, 11'd2};
      tableB2[2] = '{mk(10, 12), 1'b0, 1, 11'd15};
      tableB2[3] = '{mk(2, 4),   1'b0, 1, 11'd0};
      tableB2[4] = '{mk(0, 0),   1'b0, 1, 11'd0};

      resetA = 1'b1; resetB = 1'b1; startA = 1'b0; startB = 1'b0;
      instr = '0; ack = 1'b0; accZero = 1'b0; useB = 1'b0;
      #2;
      checkAllZero("reset");
      tick();
      resetA = 1'b0;
      resetB = 1'b0;

      // Start honoured on the first edge after reset release
      startA = 1'b1;
      tick();
      startA = 1'b0;
      checkOutput("start_fetch", {obsReq, obsBusy}, 2'b11);
      checkOutput("start_pc", obsAddr, 0);
      modelPc = 11'd0;
      for (int i = 0; i < 15; i++) applyStimulus(tableA[i]);

      // In HALT both start and stray acks are ignored
      startA = 1'b1;
      ack    = 1'b1;
      tick();
      tick();
      startA = 1'b0;
      ack    = 1'b0;
      checkOutput("halt_sticky", {obsHalted, obsBusy, obsReq}, 3'b100);
      checkOutput("halt_pc", obsAddr, 12);

      // Reset in the middle of an outstanding fetch
      resetA = 1'b1;
      tick();
      resetA = 1'b0;
      startA = 1'b1;
      tick();
      startA = 1'b0;
      checkOutput("refetch_after_reset", obsReq, 1);
      tick();
      #3;
      resetA = 1'b1;
      #1;
      checkAllZero("mid_fetch_reset");
      instr = mk(3, 5);
      ack   = 1'b1;
      tick();
      tick();
      resetA = 1'b0;
      tick();
      tick();
      ack = 1'b0;
      checkAllZero("late_ack_ignored");

      // Narrow-PC instance: short program, then wrap-around branches
      useB   = 1'b1;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      modelPc = 11'd0;
      for (int i = 0; i < 4; i++) applyStimulus(tableB1[i]);
      resetB = 1'b1;
      #1;
      checkAllZero("b_reset");
      tick();
      resetB = 1'b0;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      modelPc = 11'd0;
      for (int i = 0; i < 5; i++) applyStimulus(tableB2[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bip_seq_control.md
BIP_SEQ_CONTROL -- requirements
Module: bip_seq_control

Interface
REQ-001 Parameter PC_CANT_BITS, default 11, SHALL set the PC and instruction-address width.
REQ-002 Parameter OPCODE_LENGTH, default 5, SHALL set the opcode width.
REQ-003 Parameter OPERAND_LENGTH, default 11, SHALL set the operand width; the instruction word is OPCODE_LENGTH+OPERAND_LENGTH bits, opcode in the MSBs.
REQ-004 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_soft_reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  leaves IDLE and begins execution at PC 0.
REQ-007 i_instr  in  OPCODE_LENGTH+OPERAND_LENGTH  instruction word from program memory, valid while i_imem_ack=1.
REQ-008 i_imem_ack  in  1  program-memory handshake; data valid this cycle.
REQ-009 i_acc_zero  in  1  accumulator==0 flag from the datapath.
REQ-010 o_addr_mem  out  PC_CANT_BITS  current PC, the program-memory address.
REQ-011 o_imem_req  out  1  instruction fetch request.
REQ-012 o_operand  out  OPERAND_LENGTH  latched operand, used as data address or immediate.
REQ-013 o_selA  out  2  accumulator source: 00 data mem, 01 immediate, 10 ALU.
REQ-014 o_selB  out  1  ALU B source: 0 data mem, 1 immediate.
REQ-015 o_wrAcc, o_wr_rd_mem, o_opCode  out  1/1/OPCODE_LENGTH  accumulator write, data-mem write (1) / read (0), ALU opcode.
REQ-016 o_busy, o_halted, o_illegal  out  1/1/1  status flags.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE SHALL go to FETCH on i_start=1 with PC=0; otherwise it SHALL stay in IDLE.
REQ-019 FETCH: o_imem_req=1 every cycle, with no timeout; when i_imem_ack=1, latch i_instr and go to EXEC on the next edge.
REQ-020 EXEC SHALL last exactly one cycle, with control outputs valid only in that cycle; it goes to FETCH, or to HALT for HLT. Minimum fetch-to-fetch time is 2 cycles.
REQ-021 The opcode set SHALL be:
  - HLT=0
  - STO=1: o_wr_rd_mem=1
  - LD=2: selA=00, wrAcc
  - LDI=3: selA=01, wrAcc
  - ADD=4: selA=10, selB=0, wrAcc
  - ADDI=5: selA=10, selB=1, wrAcc
  - SUB=6: selA=10, selB=0, wrAcc
  - SUBI=7: selA=10, selB=1, wrAcc
  - BEQ=8
  - BNE=9
  - BR=10
REQ-022 At the end of EXEC, PC SHALL become PC+1 for non-branches; BR, BEQ with i_acc_zero=1, or BNE with i_acc_zero=0 SHALL load PC+1+sign-extended operand. All PC arithmetic is modulo 2^PC_CANT_BITS (wraps silently).
REQ-023 i_acc_zero SHALL be sampled in the EXEC cycle of the branch.
REQ-024 An undefined opcode SHALL execute as NOP (PC+1, no writes) and pulse o_illegal high for its EXEC cycle.
REQ-025 o_opCode SHALL equal the latched opcode in EXEC and 0 otherwise.
REQ-026 Outside EXEC, o_wrAcc, o_wr_rd_mem, o_selA, o_selB and o_illegal SHALL be 0.
REQ-027 o_busy SHALL be 1 in FETCH and EXEC; o_halted SHALL be 1 only in HALT.
REQ-028 HALT SHALL be left only by reset; i_start in HALT, FETCH or EXEC SHALL be ignored.
REQ-029 An i_imem_ack outside FETCH SHALL be ignored.

Reset
REQ-030 Asserting i_soft_reset SHALL immediately force state IDLE, PC 0, latched instruction 0 and all outputs 0, including mid-fetch and mid-EXEC; a pending fetch is abandoned.
REQ-031 The first i_start is honoured on the first clock edge after reset deasserts.

Structure
REQ-032 Package bip_pkg SHALL hold the opcode constants, the selA encodings and the FSM state encoding.
REQ-033 The PC register with its increment/branch adder SHALL be a sub-module bip_branch_pc (inputs wrPC, branch, offset).

Verification
REQ-034 Reset, pulse i_start, memory acks one cycle after each request, program LDI 5; ADDI 3; STO 7; HLT -> EXEC cycles show selA=01 then selA=10/selB=1, then o_wr_rd_mem=1 with o_operand=7; o_halted=1 with PC=3.
REQ-035 Ack delayed 4 cycles -> o_imem_req held 4 cycles, PC stable, no control pulses until EXEC.
REQ-036 BEQ -2 at PC 5 with i_acc_zero=1 -> PC=4; same instruction with i_acc_zero=0 -> PC=6; BNE mirrors this.
REQ-037 PC_CANT_BITS=4, BR +3 at PC 14 -> PC=2 (wrap-around); sequential fetch from 15 -> 0.
REQ-038 Opcode 31 -> o_illegal pulses for 1 cycle, PC+1, no writes.
REQ-039 Reset asserted during FETCH with ack pending -> immediate IDLE, all outputs 0, later ack ignored.
